sd_spi_init_sequencer: RTL



---
 rtl/sd_spi_init_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_init_sequencer.sv
// rtl/sd_spi_init_sequencer.sv - SD card SPI-mode power-up sequencer (dummy clocks, CMD0/CMD8/CMD55/ACMD41)
module sd_spi_init_sequencer #(
    parameter int HALF_SLOW    = 32,
    parameter int HALF_FAST    = 1,
    parameter int MAX_RETRY    = 255,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic       CLKin,
    input  logic       Reset,
    input  logic       MISO,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_n,
    output logic [7:0] State,
    output logic       Ready,
    output logic       Error,
    output logic [2:0] ErrCode
);
    localparam logic [7:0] S_IDLE   = 8'h00;
    localparam logic [7:0] S_DUMMY  = 8'h10;
    localparam logic [7:0] S_CMD0   = 8'h20;
    localparam logic [7:0] S_CMD8   = 8'h30;
    localparam logic [7:0] S_CMD55  = 8'h40;
    localparam logic [7:0] S_ACMD41 = 8'h50;
    localparam logic [7:0] S_READY  = 8'h70;
    localparam logic [7:0] S_ERROR  = 8'hFF;
    localparam logic [7:0] TIMEOUT_LAST = 8'(RESP_TIMEOUT - 1);
    localparam logic [7:0] RETRY_LIMIT  = 8'(MAX_RETRY);

    typedef enum logic [2:0] {PH_DUMMY, PH_FRAME, PH_POLL, PH_R7, PH_GAP} phase_t;

    logic [7:0]  state_q, state_d;
    phase_t      ph_q, ph_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [2:0]  err_q, err_d;
    logic [7:0]  r1_q, r1_d;
    logic        cs_pend_q, cs_pend_d;
    logic [7:0]  load_byte;
    logic        adv, fail;
    logic [7:0]  adv_state;
    logic [2:0]  fail_code;
    logic [7:0]  tx_q;
    logic [6:0]  rx_q;
    logic [2:0]  bit_q;
    logic [15:0] div_q, reload;
    logic        sclk_q, mosi_q, cs_q;
    logic        running, tick, rise, fall, byte_done;
    logic [7:0]  rx_byte;

    function automatic logic slow_range(input logic [7:0] s);
        return (s != 8'h00) && (s < 8'h70);
    endfunction

    function automatic logic [7:0] frame_byte(input logic [7:0] cmd, input logic [7:0] idx);
        logic [47:0] f;
        case (cmd)
            S_CMD0:   f = 48'h40_00_00_00_00_95;
            S_CMD8:   f = 48'h48_00_00_01_AA_87;
            S_CMD55:  f = 48'h77_00_00_00_00_65;
            S_ACMD41: f = 48'h69_40_00_00_00_77;
            default:  f = '1;
        endcase
        f = f << {idx[2:0], 3'b000};
        return f[47:40];
    endfunction

    // Terminal states keep the divider alive only long enough to return SCLK low.
    assign running   = slow_range(state_q) || (((state_q == S_READY) || (state_q == S_ERROR)) && sclk_q);
    assign tick      = running && (div_q == 16'd0);
    assign rise      = tick && !sclk_q;
    assign fall      = tick && sclk_q;
    assign byte_done = rise && (bit_q == 3'd7) && slow_range(state_q);
    assign rx_byte   = {rx_q, MISO};
    assign reload    = slow_range(state_d) ? 16'(HALF_SLOW - 1) : 16'(HALF_FAST - 1);

    always_ff @(posedge CLKin) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            ph_q      <= PH_DUMMY;
            cnt_q     <= '0;
            retry_q   <= '0;
            err_q     <= '0;
            r1_q      <= '0;
            cs_pend_q <= 1'b1;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            tx_q      <= 8'hFF;
            rx_q      <= '0;
            bit_q     <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            r1_q      <= r1_d;
            cs_pend_q <= cs_pend_d;
            if (!running || (div_q == 16'd0))
                div_q <= reload;
            else
                div_q <= div_q - 16'd1;
            if (tick)
                sclk_q <= ~sclk_q;
            if (rise) begin
                rx_q  <= rx_byte[6:0];
                bit_q <= bit_q + 3'd1;
            end
            // Next byte is staged at the last rising edge; MOSI and CS_n move on falling edges only.
            if (byte_done) begin
                tx_q <= load_byte;
            end else if (fall) begin
                mosi_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b1};
                cs_q   <= cs_pend_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        err_d     = err_q;
        r1_d      = r1_q;
        cs_pend_d = cs_pend_q;
        load_byte = 8'hFF;
        adv       = 1'b0;
        adv_state = state_q;
        fail      = 1'b0;
        fail_code = 3'd0;
        if (state_q == S_IDLE) begin
            state_d = S_DUMMY;
            ph_d    = PH_DUMMY;
            cnt_d   = '0;
        end else if (byte_done) begin
            case (ph_q)
                PH_DUMMY: begin
                    if (cnt_q == 8'd9) begin
                        state_d   = S_CMD0;
                        ph_d      = PH_FRAME;
                        cnt_d     = '0;
                        load_byte = frame_byte(S_CMD0, 8'd0);
                        cs_pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                PH_FRAME: begin
                    if (cnt_q == 8'd5) begin
                        ph_d  = PH_POLL;
                        cnt_d = '0;
                    end else begin
                        cnt_d     = cnt_q + 8'd1;
                        load_byte = frame_byte(state_q, cnt_q + 8'd1);
                    end
                end
                PH_POLL: begin
                    if (!rx_byte[7]) begin
                        case (state_q)
                            S_CMD0: begin
                                if (rx_byte == 8'h01) begin adv = 1'b1; adv_state = S_CMD8; end
                                else begin fail = 1'b1; fail_code = 3'd1; end
                            end
                            S_CMD8: begin
                                r1_d  = rx_byte;
                                ph_d  = PH_R7;
                                cnt_d = '0;
                            end
                            S_CMD55: begin
                                if (rx_byte[7:2] == 6'd0) begin adv = 1'b1; adv_state = S_ACMD41; end
                                else begin fail = 1'b1; fail_code = 3'd5; end
                            end
                            S_ACMD41: begin
                                if (rx_byte == 8'h00) begin
                                    adv = 1'b1; adv_state = S_READY;
                                end else if (rx_byte == 8'h01) begin
                                    retry_d = retry_q + 8'd1;
                                    if (retry_q + 8'd1 == RETRY_LIMIT) begin fail = 1'b1; fail_code = 3'd3; end
                                    else begin adv = 1'b1; adv_state = S_CMD55; end
                                end else begin
                                    fail = 1'b1; fail_code = 3'd5;
                                end
                            end
                            default: ;
                        endcase
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fail = 1'b1; fail_code = 3'd4;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                PH_R7: begin
                    if (cnt_q == 8'd3) begin
                        if ((r1_q == 8'h01) && (rx_byte == 8'hAA)) begin adv = 1'b1; adv_state = S_CMD55; end
                        else begin fail = 1'b1; fail_code = 3'd2; end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                PH_GAP: begin
                    ph_d      = PH_FRAME;
                    cnt_d     = '0;
                    load_byte = frame_byte(state_q, 8'd0);
                    cs_pend_d = 1'b0;
                end
                default: ;
            endcase
            if (adv) begin
                state_d   = adv_state;
                ph_d      = PH_GAP;
                cnt_d     = '0;
                cs_pend_d = 1'b1;
            end
            if (fail) begin
                state_d   = S_ERROR;
                err_d     = fail_code;
                cs_pend_d = 1'b1;
            end
        end
    end

    always_comb begin
        State   = state_q;
        Ready   = (state_q == S_READY);
        Error   = (state_q == S_ERROR);
        ErrCode = err_q;
        SCLK    = sclk_q;
        MOSI    = mosi_q;
        CS_n    = cs_q;
    end
endmodule
